// File: rtl/data_bus_bridge.sv
// data_bus_bridge: core load/store to word-wide req/ack memory bridge with stall, misalignment and timeout
module data_bus_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_re,
    input  logic                  i_we,
    input  logic [1:0]            i_access,
    input  logic                  i_unsigned,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic                  o_buserr,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [3:0]            o_mem_be,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    lane_q;
    logic [1:0]    acc_q;
    logic          uns_q;
    logic [31:0]   rdata_q;
    logic          buserr_q;
    logic          valid;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ext;

    // core-side decode: alignment, lane enables, store replication, load extension from latched lane
    always_comb begin
        o_misaligned = (i_access == 2'd3) | ((i_access == 2'd1) & i_addr[0]) | ((i_access == 2'd2) & (|i_addr[1:0]));
        valid        = (i_re | i_we) & ~o_misaligned;
        be_c         = i_access == 2'd0 ? 4'b0001 << i_addr[1:0] : i_access == 2'd1 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_c      = i_access == 2'd0 ? {4{i_wdata[7:0]}} : i_access == 2'd1 ? {2{i_wdata[15:0]}} : i_wdata;
        byte_sel     = i_mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel     = lane_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        ext          = acc_q == 2'd0 ? {{24{~uns_q & byte_sel[7]}}, byte_sel} :
                       acc_q == 2'd1 ? {{16{~uns_q & half_sel[15]}}, half_sel} : i_mem_rdata;
        o_stall      = (state == S_WAIT) | ((state == S_IDLE) & valid & ~i_reset);
        o_rdata      = ((state == S_IDLE) & o_misaligned) ? 32'd0 : rdata_q;
        o_buserr     = buserr_q;
    end

    // transaction FSM: accept in IDLE, hold request until ack or timeout, one DONE cycle to release the core
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lane_q      <= '0;
            acc_q       <= '0;
            uns_q       <= 1'b0;
            rdata_q     <= '0;
            buserr_q    <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else if (state == S_IDLE) begin
            buserr_q <= 1'b0;
            if (valid) begin
                state       <= S_WAIT;
                cnt         <= '0;
                rdata_q     <= '0;
                lane_q      <= i_addr[1:0];
                acc_q       <= i_access;
                uns_q       <= i_unsigned;
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_we;
                o_mem_be    <= be_c;
                o_mem_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                o_mem_wdata <= wdata_c;
            end
        end else if (state == S_WAIT) begin
            if (i_mem_ack) begin
                state     <= S_DONE;
                rdata_q   <= o_mem_we ? 32'd0 : ext;
                o_mem_req <= 1'b0;
            end else if (TIMEOUT != 0 && cnt == LIMIT) begin
                state     <= S_DONE;
                rdata_q   <= '0;
                buserr_q  <= 1'b1;
                o_mem_req <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            state    <= S_IDLE;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge: directed self-checking bench for data_bus_bridge
module tb_data_bus_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_re, i_we, i_unsigned, i_mem_ack;
    logic [1:0]  i_access;
    logic [31:0] i_wdata, i_mem_rdata;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic        o_stall, o_misaligned, o_buserr, o_mem_req, o_mem_we;
    logic [3:0]  o_mem_be;
    int          tests = 0;
    int          fails = 0;
    int          stall_n, req_n, berr_n, cyc_n;
    logic [31:0] rd_done, maddr, mwd;
    logic [3:0]  mbe;
    logic        mwe;

    data_bus_bridge #(.ADDR_WIDTH(32), .TIMEOUT(15)) dut (
        .i_clock(clk), .i_reset(rst), .i_addr(i_addr), .i_re(i_re), .i_we(i_we),
        .i_access(i_access), .i_unsigned(i_unsigned), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_stall(o_stall), .o_misaligned(o_misaligned), .o_buserr(o_buserr),
        .o_mem_addr(o_mem_addr), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one access, ack on the ack_at-th request cycle (0 = never), collect counts and DONE values
    task automatic run(input logic re, input logic we, input logic [1:0] acc, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd, input int ack_at);
        logic done;
        done = 1'b0;
        stall_n = 0; req_n = 0; berr_n = 0; cyc_n = 0; rd_done = 'x;
        i_re = re; i_we = we; i_access = acc; i_unsigned = uns; i_addr = addr; i_wdata = wd;
        i_mem_rdata = mrd;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (o_stall) stall_n++;
            if (o_buserr) berr_n++;
            if (o_mem_req) begin
                req_n++;
                maddr = o_mem_addr; mbe = o_mem_be; mwd = o_mem_wdata; mwe = o_mem_we;
                i_mem_ack = (req_n == ack_at);
            end else if (c > 0) begin
                done = 1'b1;
                i_mem_ack = 1'b0;
                rd_done = o_rdata;
                cyc_n = c + 1;
            end
            if (done) break;
            step();
            i_re = 1'b0; i_we = 1'b0; i_addr = 32'hFFFF_FFFF; i_wdata = 32'h0;
        end
        chk("access_completes", {31'd0, done}, 32'd1);
        step();
    endtask

    initial begin
        rst = 1'b1; i_addr = 32'h0; i_re = 1'b1; i_we = 1'b0; i_access = 2'd2; i_unsigned = 1'b0;
        i_wdata = 32'h0; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
        step();
        #1;
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_we", {31'd0, o_mem_we}, 32'd0);
        chk("rst_be", {28'd0, o_mem_be}, 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_buserr", {31'd0, o_buserr}, 32'd0);
        i_re = 1'b0;
        step();
        rst = 1'b0;
        step();

        run(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        chk("sw_addr", maddr, 32'h100);
        chk("sw_be", {28'd0, mbe}, 32'hF);
        chk("sw_wdata", mwd, 32'hDEADBEEF);
        chk("sw_we", {31'd0, mwe}, 32'd1);
        chk("sw_req_cycles", req_n, 1);
        chk("sw_stall_cycles", stall_n, 2);
        chk("sw_total_cycles", cyc_n, 3);
        chk("sw_rdata", rd_done, 32'h0);
        chk("idle_after_sw_stall", {31'd0, o_stall}, 32'd0);
        chk("idle_after_sw_req", {31'd0, o_mem_req}, 32'd0);

        run(1'b1, 1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'h80FF_0000, 3);
        chk("lb_s_rdata", rd_done, 32'hFFFFFF80);
        chk("lb_s_addr", maddr, 32'h200);
        chk("lb_s_be", {28'd0, mbe}, 32'h8);
        chk("lb_s_we", {31'd0, mwe}, 32'd0);
        chk("lb_s_stall_cycles", stall_n, 4);
        chk("lb_s_req_cycles", req_n, 3);
        run(1'b1, 1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'h80FF_0000, 3);
        chk("lb_u_rdata", rd_done, 32'h00000080);
        chk("lb_u_stall_cycles", stall_n, 4);

        run(1'b0, 1'b1, 2'd1, 1'b0, 32'h42, 32'h0000_1234, 32'h0, 1);
        chk("sh_be", {28'd0, mbe}, 32'hC);
        chk("sh_wdata", mwd, 32'h12341234);
        chk("sh_addr", maddr, 32'h40);
        run(1'b0, 1'b1, 2'd0, 1'b0, 32'h61, 32'h0000_00A5, 32'h0, 2);
        chk("sb_be", {28'd0, mbe}, 32'h2);
        chk("sb_wdata", mwd, 32'hA5A5A5A5);
        chk("sb_stall_cycles", stall_n, 3);

        i_re = 1'b1; i_we = 1'b0; i_access = 2'd1; i_addr = 32'h41;
        #1;
        chk("lh_mis_flag", {31'd0, o_misaligned}, 32'd1);
        chk("lh_mis_stall", {31'd0, o_stall}, 32'd0);
        chk("lh_mis_rdata", o_rdata, 32'd0);
        step();
        chk("lh_mis_req", {31'd0, o_mem_req}, 32'd0);
        i_re = 1'b0;

        run(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h1234_5678, 0);
        chk("to_req_cycles", req_n, 15);
        chk("to_stall_cycles", stall_n, 16);
        chk("to_buserr_cycles", berr_n, 1);
        chk("to_rdata", rd_done, 32'h0);
        chk("to_idle_stall", {31'd0, o_stall}, 32'd0);
        chk("to_idle_buserr", {31'd0, o_buserr}, 32'd0);
        run(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h1122_3344, 15);
        chk("ack15_buserr_cycles", berr_n, 0);
        chk("ack15_req_cycles", req_n, 15);
        chk("ack15_rdata", rd_done, 32'h11223344);

        i_re = 1'b1; i_access = 2'd2; i_addr = 32'h500;
        step();
        i_re = 1'b0;
        step();
        chk("rst_mid_req_before", {31'd0, o_mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, o_stall}, 32'd0);
        step();
        rst = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        step();
        chk("late_ack_req", {31'd0, o_mem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, o_stall}, 32'd0);
        chk("late_ack_rdata", o_rdata, 32'd0);
        i_mem_ack = 1'b0;
        run(1'b1, 1'b0, 2'd1, 1'b1, 32'h502, 32'h0, 32'hBEEF_0000, 1);
        chk("after_rst_lhu", rd_done, 32'h0000BEEF);
        chk("after_rst_stall_cycles", stall_n, 2);
        run(1'b1, 1'b0, 2'd1, 1'b0, 32'h502, 32'h0, 32'hBEEF_0000, 1);
        chk("lh_signed", rd_done, 32'hFFFFBEEF);

        run(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 32'h5555_5555, 1);
        chk("rw_we", {31'd0, mwe}, 32'd1);
        chk("rw_rdata", rd_done, 32'h0);
        chk("rw_wdata", mwd, 32'hCAFEF00D);

        i_re = 1'b1; i_access = 2'd3; i_addr = 32'h0;
        #1;
        chk("acc3_mis", {31'd0, o_misaligned}, 32'd1);
        chk("acc3_stall", {31'd0, o_stall}, 32'd0);
        i_access = 2'd2; i_addr = 32'h6;
        #1;
        chk("word_mis", {31'd0, o_misaligned}, 32'd1);
        i_re = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Load/store bridge directly downstream of the single-cycle core's data bus. Converts the core's combinational byte/half/word access into a word-wide request/acknowledge transaction on external data memory: it generates byte enables, replicates store data, and extracts and sign/zero-extends load data. While a transaction is in flight it stalls the core. It flags misaligned accesses and signals a bus error when the memory fails to acknowledge within a bounded time.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of core and memory byte addresses.
- TIMEOUT, 15, maximum WAIT cycles before a bus error; 0 disables the timeout.

Ports:
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_addr  in  ADDR_WIDTH  core byte address.
- i_re  in  1  core load request.
- i_we  in  1  core store request.
- i_access  in  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
- i_unsigned  in  1  zero-extend load data when 1; sign-extend when 0.
- i_wdata  in  32  core store data, right-aligned.
- o_rdata  out  32  extended load data returned to the core.
- o_stall  out  1  holds the core's PC and register write when 1.
- o_misaligned  out  1  access is misaligned or illegal; combinational.
- o_buserr  out  1  one-cycle pulse when the memory times out.
- o_mem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- o_mem_req  out  1  memory request, registered.
- o_mem_we  out  1  1 = write, 0 = read.
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_ack  in  1  memory completion, sampled only while o_mem_req is 1.
- i_mem_rdata  in  32  read word, valid in the same cycle as i_mem_ack.

## Operation
- Request is valid when (i_re | i_we) = 1 and o_misaligned = 0. If i_re and i_we are both 1, the access is a write and o_rdata = 0.
- Misaligned (o_misaligned = 1) in any of these cases:
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - i_access = 3.
- A misaligned access issues no memory request, holds o_stall = 0 and drives o_rdata = 0.
- Byte enables and store data:
  - byte: be = 1 << addr[1:0]; wdata = {4{i_wdata[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{i_wdata[15:0]}}.
  - word: be = 4'b1111; wdata = i_wdata.
- Load extraction: select the lane addressed by addr[1:0] (byte) or addr[1] (half), then extend according to i_unsigned. The result is latched into an internal register when the ack arrives.
- States:
  - IDLE: o_stall = valid request (combinational). On a valid request, latch addr, we, be, wdata, access and unsigned, clear the timeout counter, and go to WAIT.
  - WAIT: o_mem_req = 1, o_stall = 1.
    - On i_mem_ack: capture extended read data (0 for writes) and go to DONE.
    - Otherwise, when TIMEOUT ≠ 0 and counter = TIMEOUT−1: load 0 and go to DONE with a buserr flag.
    - Otherwise increment the counter.
  - DONE: o_stall = 0, o_rdata = latched value, o_buserr = flag. Go to IDLE unconditionally; the core advances on this edge.
- In IDLE and DONE, o_rdata comes from the latch and reads 0 unless a load just completed.
- Core inputs are ignored outside IDLE; memory-side outputs come only from latched values.

## Timing
- Reset (asynchronous): state = IDLE, o_mem_req = 0, o_mem_we = 0, o_mem_be = 0, o_mem_addr = 0, o_mem_wdata = 0, latched rdata = 0, o_buserr = 0, counter = 0. While reset is asserted, o_stall = 0.
- Reset mid-transaction drops o_mem_req immediately; an ack arriving after reset is ignored.
- Minimum access time is 3 cycles: the accept cycle (stall), WAIT with ack in its first cycle (stall), then DONE. Each additional wait state adds 1 cycle.
- o_mem_req rises on the edge after the accept cycle and falls on the edge after ack. Back-to-back accesses therefore have at least one cycle with o_mem_req = 0 (DONE).
- Timeout: o_mem_req is held for exactly TIMEOUT cycles, then DONE with o_buserr = 1 for 1 cycle.
- An ack arriving in the same cycle the counter reaches its limit counts as success; no buserr.
- o_misaligned and the IDLE-state o_stall are combinational from core inputs; all memory-side outputs are registered.

## Test plan
- Store word 0xDEADBEEF to 0x100, ack in first WAIT cycle -> mem_addr = 0x100, be = 1111, req high 1 cycle, stall 2 cycles, total 3 cycles.
- Load byte from 0x203, signed, mem_rdata = 0x80FF_0000, ack after 2 wait states -> o_rdata = 0xFFFFFF80. Unsigned -> 0x00000080. Stall 4 cycles.
- Store half 0x1234 to 0x42 -> be = 1100, wdata = 0x12341234. Load half from 0x41 -> o_misaligned = 1, no req, stall 0, o_rdata = 0.
- Load with no ack, TIMEOUT = 15 -> req high 15 cycles, then o_buserr pulse, o_rdata = 0, next cycle IDLE. Repeat with ack on the 15th cycle -> no buserr.
- Assert i_reset in the 2nd WAIT cycle -> req = 0 immediately, state IDLE; a late ack is ignored; the next load completes normally.
- i_re = i_we = 1 on word 0x10 -> mem_we = 1, o_rdata = 0. i_access = 3 -> o_misaligned = 1.
